// File: rtl/exe_mem_wb_pipe_pkg.sv
// Shared CPU pipeline package.
// Holds the default operand/data widths, the memory-port FSM state encoding and
// the forwarding-select codes consumed by the operand forwarding unit.
package exe_mem_wb_pipe_pkg;

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_DWIDTH = 16;

    // Memory handshake FSM states
    typedef enum logic [0:0] {
        StRun  = 1'b0,
        StWait = 1'b1
    } mem_state_e;

    // Operand forwarding sources, in priority order (youngest producer wins)
    typedef enum logic [1:0] {
        FwdNone  = 2'd0,
        FwdExMem = 2'd1,
        FwdMemWb = 2'd2
    } fwd_sel_e;

    // Register 0 is hard-wired, so it is never a forwarding source even though
    // the pipeline carries writes to it unaltered.
    function automatic fwd_sel_e fwd_select(
        input logic [DEF_WIDTH-1:0] src,
        input logic [DEF_WIDTH-1:0] em_dest,
        input logic                 em_wb,
        input logic [DEF_WIDTH-1:0] mw_dest,
        input logic                 mw_wb
    );
        if (src == '0) begin
            return FwdNone;
        end else if (em_wb && (em_dest == src)) begin
            return FwdExMem;
        end else if (mw_wb && (mw_dest == src)) begin
            return FwdMemWb;
        end
        return FwdNone;
    endfunction

endpackage

// File: rtl/exe_mem_wb_pipe_mem_port_ctrl.sv
// mem_port_ctrl: memory handshake FSM with wait-cycle timeout.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_memop      EX/MEM holds a valid load or store
//   i_ack        memory completes the request this cycle
//   o_req        memory request (combinational)
//   o_ready      EX/MEM may advance this cycle
//   o_timeout    request abandoned this cycle; instruction must retire anyway
//   o_err        sticky timeout flag, cleared only by reset
// TIMEOUT is the total number of request cycles allowed (must be >= 2).
module mem_port_ctrl
    import exe_mem_wb_pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_memop,
    input  logic i_ack,
    output logic o_req,
    output logic o_ready,
    output logic o_timeout,
    output logic o_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    mem_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_err;

    // EX/MEM holds while waiting, so i_memop stays high for the whole WAIT.
    assign o_req     = i_memop;
    assign o_ready   = ~(o_req & ~i_ack);
    // Last chance for an ack is the cycle where the counter hits TIMEOUT-1.
    assign o_timeout = (r_state == StWait) && (r_cnt == CW'(TIMEOUT - 1)) && !i_ack;
    assign o_err     = r_err;

    // The counter holds the number of unacknowledged request cycles so far,
    // so the initial RUN request cycle counts as the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StRun;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                StRun: begin
                    if (i_memop && !i_ack) begin
                        r_state <= StWait;
                        r_cnt   <= CW'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                StWait: begin
                    if (i_ack) begin
                        r_state <= StRun;
                        r_cnt   <= '0;
                    end else if (o_timeout) begin
                        r_state <= StRun;
                        r_cnt   <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= StRun;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/exe_mem_wb_pipe.sv
// exe_mem_wb_pipe: EX/MEM and MEM/WB pipeline registers around a stalling
// memory port.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   EX_*                         instruction presented by EX; FLUSH kills it
//   EX_READY                     EX/MEM accepts this cycle
//   MEM_REQ/WE/ADDR/WDATA        memory request side
//   MEM_ACK/RDATA                memory response side
//   EXE_MEM_OP1/WB/RES, LOAD_PEND  EX/MEM state for forwarding and hazards
//   MEM_WB_OP1/WB/DATA           writeback port
//   MEM_ERR                      sticky memory timeout flag
module exe_mem_wb_pipe
    import exe_mem_wb_pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DWIDTH  = DEF_DWIDTH,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EX_VALID,
    input  logic [WIDTH-1:0]  EX_DEST,
    input  logic              EX_WB,
    input  logic              EX_LD,
    input  logic              EX_ST,
    input  logic [DWIDTH-1:0] EX_RESULT,
    input  logic [DWIDTH-1:0] EX_SDATA,
    input  logic              FLUSH,
    output logic              EX_READY,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [DWIDTH-1:0] MEM_ADDR,
    output logic [DWIDTH-1:0] MEM_WDATA,
    input  logic              MEM_ACK,
    input  logic [DWIDTH-1:0] MEM_RDATA,
    output logic [WIDTH-1:0]  EXE_MEM_OP1,
    output logic              EXE_MEM_WB,
    output logic [DWIDTH-1:0] EXE_MEM_RES,
    output logic              LOAD_PEND,
    output logic [WIDTH-1:0]  MEM_WB_OP1,
    output logic              MEM_WB_WB,
    output logic [DWIDTH-1:0] MEM_WB_DATA,
    output logic              MEM_ERR
);

    // EX/MEM register
    logic              r_em_valid;
    logic [WIDTH-1:0]  r_em_dest;
    logic              r_em_wb;
    logic              r_em_ld;
    logic              r_em_st;
    logic [DWIDTH-1:0] r_em_res;
    logic [DWIDTH-1:0] r_em_sdata;

    // MEM/WB register
    logic              r_mw_wb;
    logic [WIDTH-1:0]  r_mw_dest;
    logic [DWIDTH-1:0] r_mw_data;

    logic              w_memop;
    logic              w_req;
    logic              w_ready;
    logic              w_timeout;
    logic              w_advance;
    logic [DWIDTH-1:0] w_wb_data;

    assign w_memop = r_em_valid & (r_em_ld | r_em_st);

    mem_port_ctrl #(
        .TIMEOUT (TIMEOUT)
    ) u_mem_port_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_memop   (w_memop),
        .i_ack     (MEM_ACK),
        .o_req     (w_req),
        .o_ready   (w_ready),
        .o_timeout (w_timeout),
        .o_err     (MEM_ERR)
    );

    // A timed-out instruction retires even though the stage is stalled.
    assign w_advance = r_em_valid & (w_ready | w_timeout);
    assign w_wb_data = r_em_ld ? (w_timeout ? '0 : MEM_RDATA) : r_em_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_em_valid <= 1'b0;
            r_em_dest  <= '0;
            r_em_wb    <= 1'b0;
            r_em_ld    <= 1'b0;
            r_em_st    <= 1'b0;
            r_em_res   <= '0;
            r_em_sdata <= '0;
        end else if (w_ready) begin
            r_em_valid <= EX_VALID & ~FLUSH;
            r_em_dest  <= EX_DEST;
            r_em_wb    <= EX_WB;
            r_em_ld    <= EX_LD;
            r_em_st    <= EX_ST;
            r_em_res   <= EX_RESULT;
            r_em_sdata <= EX_SDATA;
        end else if (w_timeout) begin
            // Instruction retired on timeout; stop it from re-requesting.
            r_em_valid <= 1'b0;
        end
    end

    // Stalled cycles load a bubble; destination and data hold their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mw_wb   <= 1'b0;
            r_mw_dest <= '0;
            r_mw_data <= '0;
        end else begin
            r_mw_wb <= w_advance & r_em_wb;
            if (w_advance) begin
                r_mw_dest <= r_em_dest;
                r_mw_data <= w_wb_data;
            end
        end
    end

    assign EX_READY    = w_ready;
    assign MEM_REQ     = w_req;
    assign MEM_WE      = w_req & r_em_st;
    assign MEM_ADDR    = r_em_res;
    assign MEM_WDATA   = r_em_sdata;
    assign EXE_MEM_OP1 = r_em_dest;
    // Load data does not exist yet in EX/MEM, so loads are never forwardable here.
    assign EXE_MEM_WB  = r_em_valid & r_em_wb & ~r_em_ld;
    assign EXE_MEM_RES = r_em_res;
    assign LOAD_PEND   = r_em_valid & r_em_ld;
    assign MEM_WB_OP1  = r_mw_dest;
    assign MEM_WB_WB   = r_mw_wb;
    assign MEM_WB_DATA = r_mw_data;

endmodule

// File: tb/tb_exe_mem_wb_pipe.sv
// Directed bench for exe_mem_wb_pipe: ALU pass-through, stalled load, zero-wait
// store, load timeout, flush, and reset while waiting on memory.
module tb_exe_mem_wb_pipe;

    localparam int unsigned WIDTH   = 4;
    localparam int unsigned DWIDTH  = 16;
    localparam int unsigned TIMEOUT = 8;

    logic              clk;
    logic              rst;
    logic              EX_VALID;
    logic [WIDTH-1:0]  EX_DEST;
    logic              EX_WB;
    logic              EX_LD;
    logic              EX_ST;
    logic [DWIDTH-1:0] EX_RESULT;
    logic [DWIDTH-1:0] EX_SDATA;
    logic              FLUSH;
    logic              EX_READY;
    logic              MEM_REQ;
    logic              MEM_WE;
    logic [DWIDTH-1:0] MEM_ADDR;
    logic [DWIDTH-1:0] MEM_WDATA;
    logic              MEM_ACK;
    logic [DWIDTH-1:0] MEM_RDATA;
    logic [WIDTH-1:0]  EXE_MEM_OP1;
    logic              EXE_MEM_WB;
    logic [DWIDTH-1:0] EXE_MEM_RES;
    logic              LOAD_PEND;
    logic [WIDTH-1:0]  MEM_WB_OP1;
    logic              MEM_WB_WB;
    logic [DWIDTH-1:0] MEM_WB_DATA;
    logic              MEM_ERR;

    int n_checks = 0;
    int n_errs   = 0;

    exe_mem_wb_pipe #(
        .WIDTH   (WIDTH),
        .DWIDTH  (DWIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .EX_VALID    (EX_VALID),
        .EX_DEST     (EX_DEST),
        .EX_WB       (EX_WB),
        .EX_LD       (EX_LD),
        .EX_ST       (EX_ST),
        .EX_RESULT   (EX_RESULT),
        .EX_SDATA    (EX_SDATA),
        .FLUSH       (FLUSH),
        .EX_READY    (EX_READY),
        .MEM_REQ     (MEM_REQ),
        .MEM_WE      (MEM_WE),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_ACK     (MEM_ACK),
        .MEM_RDATA   (MEM_RDATA),
        .EXE_MEM_OP1 (EXE_MEM_OP1),
        .EXE_MEM_WB  (EXE_MEM_WB),
        .EXE_MEM_RES (EXE_MEM_RES),
        .LOAD_PEND   (LOAD_PEND),
        .MEM_WB_OP1  (MEM_WB_OP1),
        .MEM_WB_WB   (MEM_WB_WB),
        .MEM_WB_DATA (MEM_WB_DATA),
        .MEM_ERR     (MEM_ERR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_drive(input logic v, input logic [WIDTH-1:0] dest, input logic wb,
                            input logic ld, input logic st, input logic [DWIDTH-1:0] res,
                            input logic [DWIDTH-1:0] sdata, input logic flush);
        EX_VALID  = v;
        EX_DEST   = dest;
        EX_WB     = wb;
        EX_LD     = ld;
        EX_ST     = st;
        EX_RESULT = res;
        EX_SDATA  = sdata;
        FLUSH     = flush;
    endtask

    task automatic ex_idle();
        ex_drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        MEM_ACK   = 1'b0;
        MEM_RDATA = '0;
        ex_idle();
        repeat (2) tick();
        rst = 1'b0;
        #1;
        // Reset state
        check_eq("rst_ready",    EX_READY,    1);
        check_eq("rst_req",      MEM_REQ,     0);
        check_eq("rst_err",      MEM_ERR,     0);
        check_eq("rst_em_wb",    EXE_MEM_WB,  0);
        check_eq("rst_mw_wb",    MEM_WB_WB,   0);
        check_eq("rst_ldpend",   LOAD_PEND,   0);
        check_eq("rst_mw_data",  MEM_WB_DATA, 0);

        // ALU op: DEST=3, RESULT=0x0042
        ex_drive(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0042, 16'h0, 1'b0);
        tick();
        ex_idle();
        #1;
        check_eq("alu_em_wb",   EXE_MEM_WB,  1);
        check_eq("alu_em_op1",  EXE_MEM_OP1, 3);
        check_eq("alu_em_res",  EXE_MEM_RES, 16'h0042);
        check_eq("alu_no_req",  MEM_REQ,     0);
        tick();
        check_eq("alu_mw_wb",   MEM_WB_WB,   1);
        check_eq("alu_mw_op1",  MEM_WB_OP1,  3);
        check_eq("alu_mw_data", MEM_WB_DATA, 16'h0042);
        check_eq("alu_em_gone", EXE_MEM_WB,  0);
        tick();
        check_eq("alu_mw_once", MEM_WB_WB,   0);

        // Load at 0x0010, ack on the fourth request cycle with 0xBEEF
        ex_drive(1'b1, 4'd7, 1'b1, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
        tick();
        ex_idle();
        #1;
        check_eq("ld_req",      MEM_REQ,    1);
        check_eq("ld_we",       MEM_WE,     0);
        check_eq("ld_addr",     MEM_ADDR,   16'h0010);
        check_eq("ld_pend",     LOAD_PEND,  1);
        check_eq("ld_no_fwd",   EXE_MEM_WB, 0);
        check_eq("ld_stall0",   EX_READY,   0);
        tick();
        check_eq("ld_stall1",   EX_READY,   0);
        check_eq("ld_req_hold", MEM_REQ,    1);
        check_eq("ld_addr_hold", MEM_ADDR,  16'h0010);
        check_eq("ld_bubble",   MEM_WB_WB,  0);
        tick();
        check_eq("ld_stall2",   EX_READY,   0);
        check_eq("ld_pend2",    LOAD_PEND,  1);
        tick();
        MEM_ACK   = 1'b1;
        MEM_RDATA = 16'hBEEF;
        #1;
        check_eq("ld_ack_ready", EX_READY,  1);
        tick();
        MEM_ACK   = 1'b0;
        MEM_RDATA = 16'h0;
        #1;
        check_eq("ld_mw_wb",    MEM_WB_WB,   1);
        check_eq("ld_mw_op1",   MEM_WB_OP1,  7);
        check_eq("ld_mw_data",  MEM_WB_DATA, 16'hBEEF);
        check_eq("ld_req_done", MEM_REQ,     0);
        check_eq("ld_pend_clr", LOAD_PEND,   0);

        // Store at 0x0020 with same-cycle ack, ALU op (DEST=4) right behind it
        ex_drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 16'h0020, 16'h1234, 1'b0);
        tick();
        MEM_ACK = 1'b1;
        ex_drive(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 16'h0055, 16'h0, 1'b0);
        #1;
        check_eq("st_req",      MEM_REQ,   1);
        check_eq("st_we",       MEM_WE,    1);
        check_eq("st_addr",     MEM_ADDR,  16'h0020);
        check_eq("st_wdata",    MEM_WDATA, 16'h1234);
        check_eq("st_no_stall", EX_READY,  1);
        tick();
        MEM_ACK   = 1'b1;  // ack with no request must be ignored
        MEM_RDATA = 16'hDEAD;
        ex_idle();
        #1;
        check_eq("st_we_once",  MEM_WE,      0);
        check_eq("st_mw_wb",    MEM_WB_WB,   0);
        check_eq("st_next_op1", EXE_MEM_OP1, 4);
        check_eq("st_next_wb",  EXE_MEM_WB,  1);
        tick();
        MEM_ACK   = 1'b0;
        MEM_RDATA = 16'h0;
        #1;
        check_eq("st_alu_wb",   MEM_WB_WB,   1);
        check_eq("st_alu_data", MEM_WB_DATA, 16'h0055);
        tick();
        check_eq("stray_ack_wb",   MEM_WB_WB,   0);
        check_eq("stray_ack_data", MEM_WB_DATA, 16'h0055);

        // Load with no ack: request held for TIMEOUT cycles then dropped
        ex_drive(1'b1, 4'd9, 1'b1, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0);
        tick();
        ex_idle();
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            #1;
            check_eq($sformatf("to_req_%0d", i), MEM_REQ, 1);
            check_eq($sformatf("to_err_%0d", i), MEM_ERR, 0);
            tick();
        end
        check_eq("to_req_drop", MEM_REQ,     0);
        check_eq("to_err",      MEM_ERR,     1);
        check_eq("to_mw_wb",    MEM_WB_WB,   1);
        check_eq("to_mw_op1",   MEM_WB_OP1,  9);
        check_eq("to_mw_data",  MEM_WB_DATA, 0);
        check_eq("to_ready",    EX_READY,    1);

        // FLUSH during capture of DEST=5
        ex_drive(1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 16'h0077, 16'h0, 1'b1);
        tick();
        ex_idle();
        #1;
        check_eq("fl_em_wb",    EXE_MEM_WB, 0);
        check_eq("fl_err_stky", MEM_ERR,    1);
        tick();
        check_eq("fl_mw_wb",    MEM_WB_WB,  0);
        check_eq("fl_mw_op1",   MEM_WB_OP1, 9);

        // Reset while waiting on a load
        ex_drive(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0);
        tick();
        ex_idle();
        tick();
        check_eq("rw_in_wait",  MEM_REQ, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("rw_req",      MEM_REQ,     0);
        check_eq("rw_err",      MEM_ERR,     0);
        check_eq("rw_ready",    EX_READY,    1);
        check_eq("rw_em_op1",   EXE_MEM_OP1, 0);
        check_eq("rw_mw_op1",   MEM_WB_OP1,  0);
        check_eq("rw_ldpend",   LOAD_PEND,   0);

        // Destination 0 passes through unaltered
        ex_drive(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h00A5, 16'h0, 1'b0);
        tick();
        ex_idle();
        #1;
        check_eq("r0_em_wb",    EXE_MEM_WB,  1);
        tick();
        check_eq("r0_mw_wb",    MEM_WB_WB,   1);
        check_eq("r0_mw_data",  MEM_WB_DATA, 16'h00A5);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
